// File: rtl/seq_detector_param.sv
// seq_detector_param
// Serial pattern detector. One bit is accepted per cycle when x_valid is high,
// and the newest PAT_W accepted bits are compared with a pattern that can be
// reloaded at run time. Each match produces a one-cycle y_out pulse and
// advances a saturating match counter. Detection can be overlapping or
// non-overlapping.
module seq_detector_param #(
   parameter int                 PAT_W     = 4,
   parameter int                 CNT_W     = 8,
   parameter bit                 OVERLAP   = 1'b1,
   parameter logic [PAT_W-1:0]   PAT_RESET = PAT_W'(4'b1011)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              x_in,
   input  logic              x_valid,
   input  logic [PAT_W-1:0]  pattern,
   input  logic              load_pat,
   input  logic              cnt_clr,
   output logic              y_out,
   output logic              armed,
   output logic [CNT_W-1:0]  match_cnt,
   output logic              cnt_sat
);

   // Only the PAT_W-1 older bits are stored. The newest bit is taken directly
   // from x_in when the comparison is made.
   localparam int                HIST_W   = PAT_W - 1;
   localparam int                FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      ARMED = 2'd2
   } state_t;

   state_t              state, state_next;
   logic [HIST_W-1:0]   hist, hist_next;
   logic [FILL_W-1:0]   fill, fill_next;
   logic [PAT_W-1:0]    pat_reg;
   logic [PAT_W-1:0]    window;
   logic [CNT_W-1:0]    cnt_next;
   logic                sat_next;
   logic                match;

   // Candidate window: the stored history with the current bit appended as
   // the newest (least significant) bit.
   assign window = {hist, x_in};

   // A pattern load discards the bit offered in the same cycle, so no match
   // can be reported in that cycle.
   assign match = x_valid & ~load_pat & (state == ARMED) & (window == pat_reg);

   // Next-state logic for the window, fill level and FSM state.
   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
      hist_next  = hist;
      fill_next  = fill;
      state_next = state;
      if (load_pat) begin
         hist_next  = '0;
         fill_next  = '0;
         state_next = EMPTY;
      end else if (x_valid) begin
         hist_next  = window[HIST_W-1:0];
         fill_next  = (fill == FILL_MAX) ? fill : fill + 1'b1;
         state_next = (fill_next == FILL_MAX) ? ARMED : FILL;
         if (match && (OVERLAP == 1'b0)) begin
            hist_next  = '0;
            fill_next  = '0;
            state_next = EMPTY;
         end
      end
   end

   // Counter next value. A clear takes effect first, then a match in the
   // same cycle is counted on top of it.
   always_comb begin
      cnt_next = match_cnt;
      sat_next = cnt_sat;
      if (cnt_clr) begin
         cnt_next = match ? CNT_W'(1) : '0;
         sat_next = 1'b0;
      end else if (match) begin
         if (match_cnt == {CNT_W{1'b1}}) begin
            sat_next = 1'b1;
         end else begin
            cnt_next = match_cnt + 1'b1;
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so that all registers update together at the clock edge.
      if (!reset) begin
         state     <= EMPTY;
         hist      <= '0;
         fill      <= '0;
         pat_reg   <= PAT_RESET;
         y_out     <= 1'b0;
         armed     <= 1'b0;
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else begin
         state     <= state_next;
         hist      <= hist_next;
         fill      <= fill_next;
         if (load_pat) begin
            pat_reg <= pattern;
         end
         y_out     <= match;
         armed     <= (state_next == ARMED);
         match_cnt <= cnt_next;
         cnt_sat   <= sat_next;
      end
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed testbench for seq_detector_param. Three instances share one
// stimulus bus: the default configuration, a non-overlapping variant, and a
// variant with a 2-bit counter.
module tb_seq_detector_param;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        x_in = 1'b0;
   logic        x_valid = 1'b0;
   logic [3:0]  pattern = 4'b0000;
   logic        load_pat = 1'b0;
   logic        cnt_clr = 1'b0;

   logic        y_ov, armed_ov, sat_ov;
   logic [7:0]  cnt_ov;
   logic        y_no, armed_no, sat_no;
   logic [7:0]  cnt_no;
   logic        y_c2, armed_c2, sat_c2;
   logic [1:0]  cnt_c2;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   seq_detector_param #(.PAT_W(4), .CNT_W(8), .OVERLAP(1'b1)) dut_ov (
      .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
      .pattern(pattern), .load_pat(load_pat), .cnt_clr(cnt_clr),
      .y_out(y_ov), .armed(armed_ov), .match_cnt(cnt_ov), .cnt_sat(sat_ov));

   seq_detector_param #(.PAT_W(4), .CNT_W(8), .OVERLAP(1'b0)) dut_no (
      .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
      .pattern(pattern), .load_pat(load_pat), .cnt_clr(cnt_clr),
      .y_out(y_no), .armed(armed_no), .match_cnt(cnt_no), .cnt_sat(sat_no));

   seq_detector_param #(.PAT_W(4), .CNT_W(2), .OVERLAP(1'b1)) dut_c2 (
      .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
      .pattern(pattern), .load_pat(load_pat), .cnt_clr(cnt_clr),
      .y_out(y_c2), .armed(armed_c2), .match_cnt(cnt_c2), .cnt_sat(sat_c2));

   typedef struct {
      logic       x;
      logic       v;
      logic       ld;
      logic [3:0] pat;
      logic       clr;
      logic       ey;
      logic       ea;
      logic [7:0] ec;
   } vec_t;

   vec_t vecs [22];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Apply one cycle of stimulus. Outputs are sampled 1 time unit after the edge.
   task automatic step(input logic x, input logic v, input logic ld,
                       input logic [3:0] pat, input logic clr);
      x_in = x; x_valid = v; load_pat = ld; pattern = pat; cnt_clr = clr;
      @(posedge clock);
      #1;
   endtask

   task automatic bit_in(input logic x);
      step(x, 1'b1, 1'b0, 4'b0000, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      reset = 1'b1;
   endtask

   initial begin
      // x, v, ld, pat, clr, exp y, exp armed, exp cnt (overlapping instance)
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd0};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 8'd1};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd1};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd1};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 8'd2};
      // Reload 1011 to flush the window, then 1,0,gap of 3,1,1.
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 8'd2};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd2};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 8'd3};
      // Load 0110 with a valid bit in the same cycle; the bit is discarded.
      vecs[15] = '{1'b1, 1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 8'd3};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd3};
      vecs[17] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd3};
      vecs[18] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd3};
      vecs[19] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 8'd4};
      // Clear without a match, then a non-matching bit.
      vecs[20] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 8'd0};
      vecs[21] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd0};

      // Reset state of all instances
      do_reset();
      check("rst_y_ov", 32'(y_ov), 32'd0);
      check("rst_armed_ov", 32'(armed_ov), 32'd0);
      check("rst_cnt_ov", 32'(cnt_ov), 32'd0);
      check("rst_sat_ov", 32'(sat_ov), 32'd0);
      check("rst_y_no", 32'(y_no), 32'd0);
      check("rst_cnt_c2", 32'(cnt_c2), 32'd0);
      check("rst_sat_c2", 32'(sat_c2), 32'd0);

      // Table-driven vectors against the overlapping instance
      for (int i = 0; i < 22; i++) begin
         step(vecs[i].x, vecs[i].v, vecs[i].ld, vecs[i].pat, vecs[i].clr);
         check($sformatf("vec%0d_y", i), 32'(y_ov), 32'(vecs[i].ey));
         check($sformatf("vec%0d_armed", i), 32'(armed_ov), 32'(vecs[i].ea));
         check($sformatf("vec%0d_cnt", i), 32'(cnt_ov), 32'(vecs[i].ec));
      end

      // Non-overlapping detection: 1,0,1,1,0,1,1
      do_reset();
      bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
      check("no_armed_b3", 32'(armed_no), 32'd1);
      bit_in(1'b1);
      check("no_y_b4", 32'(y_no), 32'd1);
      check("no_armed_b4", 32'(armed_no), 32'd0);
      check("no_cnt_b4", 32'(cnt_no), 32'd1);
      bit_in(1'b0);
      check("no_armed_b5", 32'(armed_no), 32'd0);
      bit_in(1'b1);
      check("no_armed_b6", 32'(armed_no), 32'd0);
      bit_in(1'b1);
      check("no_y_b7", 32'(y_no), 32'd0);
      check("no_armed_b7", 32'(armed_no), 32'd1);
      check("no_cnt_b7", 32'(cnt_no), 32'd1);

      // 2-bit counter: five overlapping matches, then clear with a match
      do_reset();
      bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            bit_in(1'b0); bit_in(1'b1);
         end
         bit_in(1'b1);
         check($sformatf("c2_m%0d_y", k), 32'(y_c2), 32'd1);
         check($sformatf("c2_m%0d_cnt", k), 32'(cnt_c2), (k < 3) ? 32'(k + 1) : 32'd3);
         check($sformatf("c2_m%0d_sat", k), 32'(sat_c2), (k >= 3) ? 32'd1 : 32'd0);
      end
      bit_in(1'b0); bit_in(1'b1);
      step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
      check("c2_clr_y", 32'(y_c2), 32'd1);
      check("c2_clr_cnt", 32'(cnt_c2), 32'd1);
      check("c2_clr_sat", 32'(sat_c2), 32'd0);

      // Reset mid-stream discards the partial window and restores the pattern
      do_reset();
      pattern = 4'h6;
      step(1'b0, 1'b0, 1'b1, 4'h6, 1'b0);
      do_reset();
      bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
      reset = 1'b0;
      step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      check("mid_rst_y", 32'(y_ov), 32'd0);
      check("mid_rst_armed", 32'(armed_ov), 32'd0);
      check("mid_rst_cnt", 32'(cnt_ov), 32'd0);
      check("mid_rst_sat", 32'(sat_ov), 32'd0);
      reset = 1'b1;
      bit_in(1'b1);
      check("post_rst_y", 32'(y_ov), 32'd0);
      check("post_rst_armed", 32'(armed_ov), 32'd0);
      bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
      check("post_rst_match_y", 32'(y_ov), 32'd1);
      check("post_rst_match_cnt", 32'(cnt_ov), 32'd1);
      bit_in(1'b0);
      check("post_rst_pulse_end", 32'(y_ov), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
